// File: rtl/ace_multicut_pkg.sv
// ----------------------------------------------------------------------------
// ace_multicut_pkg : channel indices and default ACE payload/link structs
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ace_multicut_pkg;

  localparam int unsigned NumChan = 8;
  localparam int unsigned ChanAw  = 0;
  localparam int unsigned ChanW   = 1;
  localparam int unsigned ChanB   = 2;
  localparam int unsigned ChanAr  = 3;
  localparam int unsigned ChanR   = 4;
  localparam int unsigned ChanAc  = 5;
  localparam int unsigned ChanCr  = 6;
  localparam int unsigned ChanCd  = 7;

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ace_mc_aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } ace_mc_w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } ace_mc_b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ace_mc_ar_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [3:0] resp; logic last; } ace_mc_r_t;
  typedef struct packed { logic [31:0] addr; logic [3:0] snoop; logic [2:0] prot; } ace_mc_ac_t;
  typedef struct packed { logic [4:0] resp; } ace_mc_cr_t;
  typedef struct packed { logic [31:0] data; logic last; } ace_mc_cd_t;

  typedef struct packed {
    logic       aw_valid;
    ace_mc_aw_t aw;
    logic       w_valid;
    ace_mc_w_t  w;
    logic       b_ready;
    logic       ar_valid;
    ace_mc_ar_t ar;
    logic       r_ready;
    logic       wack;
    logic       rack;
  } ace_mc_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       w_ready;
    logic       b_valid;
    ace_mc_b_t  b;
    logic       ar_ready;
    logic       r_valid;
    ace_mc_r_t  r;
  } ace_mc_resp_t;

  typedef struct packed {
    logic       ac_valid;
    ace_mc_ac_t ac;
    logic       cr_ready;
    logic       cd_ready;
  } ace_mc_snp_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    ace_mc_cr_t cr;
    logic       cd_valid;
    ace_mc_cd_t cd;
  } ace_mc_snp_resp_t;

endpackage

`default_nettype wire

// File: rtl/ace_multicut_spill.sv
// ----------------------------------------------------------------------------
// ace_spill_stage : two-entry handshake-cutting register stage (A out, B overflow)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ace_spill_stage #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic busy_o
);

  logic a_full_q, a_full_d, b_full_q, b_full_d;
  T     a_q, a_d, b_q, b_d;
  logic push, pop;

  // Ready is held low throughout reset so nothing is accepted into a clearing stage.
  assign ready_o = !b_full_q && !rst_i;
  assign valid_o = a_full_q;
  assign data_o  = a_q;
  assign busy_o  = a_full_q | b_full_q;

  always_comb begin
    a_full_d = a_full_q;
    b_full_d = b_full_q;
    a_d      = a_q;
    b_d      = b_q;
    push     = valid_i && ready_o;
    pop      = a_full_q && ready_i;
    if (b_full_q) begin
      if (pop) begin
        a_d      = b_q;
        b_full_d = 1'b0;
      end
    end else if (push) begin
      if (a_full_q && !pop) begin
        b_d      = data_i;
        b_full_d = 1'b1;
      end else begin
        a_d      = data_i;
        a_full_d = 1'b1;
      end
    end else if (pop) begin
      a_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ace_multicut.sv
// ----------------------------------------------------------------------------
// ace_multicut : per-channel multi-stage register cut for ACE + snoop links
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ace_multicut
  import ace_multicut_pkg::*;
#(
  parameter int unsigned NumCuts  = 1,
  parameter logic [7:0]  ChanMask = 8'hFF,
  parameter int unsigned AckCuts  = 1,
  parameter type aw_chan_t    = ace_mc_aw_t,
  parameter type w_chan_t     = ace_mc_w_t,
  parameter type b_chan_t     = ace_mc_b_t,
  parameter type ar_chan_t    = ace_mc_ar_t,
  parameter type r_chan_t     = ace_mc_r_t,
  parameter type ac_chan_t    = ace_mc_ac_t,
  parameter type cr_chan_t    = ace_mc_cr_t,
  parameter type cd_chan_t    = ace_mc_cd_t,
  parameter type ace_req_t    = ace_mc_req_t,
  parameter type ace_resp_t   = ace_mc_resp_t,
  parameter type snoop_req_t  = ace_mc_snp_req_t,
  parameter type snoop_resp_t = ace_mc_snp_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  ace_req_t    slv_req_i,
  output ace_resp_t   slv_resp_o,
  output ace_req_t    mst_req_o,
  input  ace_resp_t   mst_resp_i,
  output snoop_req_t  slv_snp_req_o,
  input  snoop_resp_t slv_snp_resp_i,
  input  snoop_req_t  mst_snp_req_i,
  output snoop_resp_t mst_snp_resp_o,
  output logic        idle_o
);

  logic [NumChan-1:0] chan_busy;
  logic               ack_busy;

  if (ChanMask[ChanAw] && (NumCuts > 0)) begin : g_aw_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    aw_chan_t           dat [0:NumCuts];
    assign vld[0] = slv_req_i.aw_valid;
    assign dat[0] = slv_req_i.aw;
    assign slv_resp_o.aw_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(aw_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign mst_req_o.aw_valid = vld[NumCuts];
    assign mst_req_o.aw       = dat[NumCuts];
    assign rdy[NumCuts]       = mst_resp_i.aw_ready;
    assign chan_busy[ChanAw]  = |st;
  end else begin : g_aw_wire
    assign mst_req_o.aw_valid  = slv_req_i.aw_valid;
    assign mst_req_o.aw        = slv_req_i.aw;
    assign slv_resp_o.aw_ready = mst_resp_i.aw_ready;
    assign chan_busy[ChanAw]   = 1'b0;
  end

  if (ChanMask[ChanW] && (NumCuts > 0)) begin : g_w_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    w_chan_t            dat [0:NumCuts];
    assign vld[0] = slv_req_i.w_valid;
    assign dat[0] = slv_req_i.w;
    assign slv_resp_o.w_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(w_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign mst_req_o.w_valid = vld[NumCuts];
    assign mst_req_o.w       = dat[NumCuts];
    assign rdy[NumCuts]      = mst_resp_i.w_ready;
    assign chan_busy[ChanW]  = |st;
  end else begin : g_w_wire
    assign mst_req_o.w_valid  = slv_req_i.w_valid;
    assign mst_req_o.w        = slv_req_i.w;
    assign slv_resp_o.w_ready = mst_resp_i.w_ready;
    assign chan_busy[ChanW]   = 1'b0;
  end

  if (ChanMask[ChanB] && (NumCuts > 0)) begin : g_b_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    b_chan_t            dat [0:NumCuts];
    assign vld[0] = mst_resp_i.b_valid;
    assign dat[0] = mst_resp_i.b;
    assign mst_req_o.b_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(b_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign slv_resp_o.b_valid = vld[NumCuts];
    assign slv_resp_o.b       = dat[NumCuts];
    assign rdy[NumCuts]       = slv_req_i.b_ready;
    assign chan_busy[ChanB]   = |st;
  end else begin : g_b_wire
    assign slv_resp_o.b_valid = mst_resp_i.b_valid;
    assign slv_resp_o.b       = mst_resp_i.b;
    assign mst_req_o.b_ready  = slv_req_i.b_ready;
    assign chan_busy[ChanB]   = 1'b0;
  end

  if (ChanMask[ChanAr] && (NumCuts > 0)) begin : g_ar_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    ar_chan_t           dat [0:NumCuts];
    assign vld[0] = slv_req_i.ar_valid;
    assign dat[0] = slv_req_i.ar;
    assign slv_resp_o.ar_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(ar_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign mst_req_o.ar_valid = vld[NumCuts];
    assign mst_req_o.ar       = dat[NumCuts];
    assign rdy[NumCuts]       = mst_resp_i.ar_ready;
    assign chan_busy[ChanAr]  = |st;
  end else begin : g_ar_wire
    assign mst_req_o.ar_valid  = slv_req_i.ar_valid;
    assign mst_req_o.ar        = slv_req_i.ar;
    assign slv_resp_o.ar_ready = mst_resp_i.ar_ready;
    assign chan_busy[ChanAr]   = 1'b0;
  end

  if (ChanMask[ChanR] && (NumCuts > 0)) begin : g_r_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    r_chan_t            dat [0:NumCuts];
    assign vld[0] = mst_resp_i.r_valid;
    assign dat[0] = mst_resp_i.r;
    assign mst_req_o.r_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(r_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign slv_resp_o.r_valid = vld[NumCuts];
    assign slv_resp_o.r       = dat[NumCuts];
    assign rdy[NumCuts]       = slv_req_i.r_ready;
    assign chan_busy[ChanR]   = |st;
  end else begin : g_r_wire
    assign slv_resp_o.r_valid = mst_resp_i.r_valid;
    assign slv_resp_o.r       = mst_resp_i.r;
    assign mst_req_o.r_ready  = slv_req_i.r_ready;
    assign chan_busy[ChanR]   = 1'b0;
  end

  if (ChanMask[ChanAc] && (NumCuts > 0)) begin : g_ac_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    ac_chan_t           dat [0:NumCuts];
    assign vld[0] = mst_snp_req_i.ac_valid;
    assign dat[0] = mst_snp_req_i.ac;
    assign mst_snp_resp_o.ac_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(ac_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign slv_snp_req_o.ac_valid = vld[NumCuts];
    assign slv_snp_req_o.ac       = dat[NumCuts];
    assign rdy[NumCuts]           = slv_snp_resp_i.ac_ready;
    assign chan_busy[ChanAc]      = |st;
  end else begin : g_ac_wire
    assign slv_snp_req_o.ac_valid  = mst_snp_req_i.ac_valid;
    assign slv_snp_req_o.ac        = mst_snp_req_i.ac;
    assign mst_snp_resp_o.ac_ready = slv_snp_resp_i.ac_ready;
    assign chan_busy[ChanAc]       = 1'b0;
  end

  if (ChanMask[ChanCr] && (NumCuts > 0)) begin : g_cr_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    cr_chan_t           dat [0:NumCuts];
    assign vld[0] = slv_snp_resp_i.cr_valid;
    assign dat[0] = slv_snp_resp_i.cr;
    assign slv_snp_req_o.cr_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(cr_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign mst_snp_resp_o.cr_valid = vld[NumCuts];
    assign mst_snp_resp_o.cr       = dat[NumCuts];
    assign rdy[NumCuts]            = mst_snp_req_i.cr_ready;
    assign chan_busy[ChanCr]       = |st;
  end else begin : g_cr_wire
    assign mst_snp_resp_o.cr_valid = slv_snp_resp_i.cr_valid;
    assign mst_snp_resp_o.cr       = slv_snp_resp_i.cr;
    assign slv_snp_req_o.cr_ready  = mst_snp_req_i.cr_ready;
    assign chan_busy[ChanCr]       = 1'b0;
  end

  if (ChanMask[ChanCd] && (NumCuts > 0)) begin : g_cd_cut
    logic [NumCuts:0]   vld;
    logic [NumCuts:0]   rdy;
    logic [NumCuts-1:0] st;
    cd_chan_t           dat [0:NumCuts];
    assign vld[0] = slv_snp_resp_i.cd_valid;
    assign dat[0] = slv_snp_resp_i.cd;
    assign slv_snp_req_o.cd_ready = rdy[0];
    for (genvar s = 0; s < NumCuts; s++) begin : g_stage
      ace_spill_stage #(.T(cd_chan_t)) u_stage (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1]),
        .busy_o  (st[s])
      );
    end
    assign mst_snp_resp_o.cd_valid = vld[NumCuts];
    assign mst_snp_resp_o.cd       = dat[NumCuts];
    assign rdy[NumCuts]            = mst_snp_req_i.cd_ready;
    assign chan_busy[ChanCd]       = |st;
  end else begin : g_cd_wire
    assign mst_snp_resp_o.cd_valid = slv_snp_resp_i.cd_valid;
    assign mst_snp_resp_o.cd       = slv_snp_resp_i.cd;
    assign slv_snp_req_o.cd_ready  = mst_snp_req_i.cd_ready;
    assign chan_busy[ChanCd]       = 1'b0;
  end

  // wack/rack are single-cycle pulses, so a plain shift register keeps them exact.
  if (AckCuts > 0) begin : g_ack_cut
    logic [AckCuts-1:0] wack_q, wack_d, rack_q, rack_d;

    always_comb begin
      wack_d = AckCuts'({wack_q, slv_req_i.wack});
      rack_d = AckCuts'({rack_q, slv_req_i.rack});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wack_q <= '0;
        rack_q <= '0;
      end else begin
        wack_q <= wack_d;
        rack_q <= rack_d;
      end
    end

    assign mst_req_o.wack = wack_q[AckCuts-1];
    assign mst_req_o.rack = rack_q[AckCuts-1];
    assign ack_busy       = (|wack_q) | (|rack_q);
  end else begin : g_ack_wire
    assign mst_req_o.wack = slv_req_i.wack;
    assign mst_req_o.rack = slv_req_i.rack;
    assign ack_busy       = 1'b0;
  end

  assign idle_o = !(|chan_busy) && !ack_busy;

endmodule

`default_nettype wire

// File: tb/tb_ace_multicut.sv
// ----------------------------------------------------------------------------
// tb_ace_multicut : scoreboard bench over three configurations of ace_multicut
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ace_multicut;
  import ace_multicut_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ace_mc_req_t      a_slv_req, a_mst_req, b_slv_req, b_mst_req, c_slv_req, c_mst_req;
  ace_mc_resp_t     a_slv_resp, a_mst_resp, b_slv_resp, b_mst_resp, c_slv_resp, c_mst_resp;
  ace_mc_snp_req_t  a_slv_snp_req, a_mst_snp_req, b_slv_snp_req, b_mst_snp_req, c_slv_snp_req, c_mst_snp_req;
  ace_mc_snp_resp_t a_slv_snp_resp, a_mst_snp_resp, b_slv_snp_resp, b_mst_snp_resp, c_slv_snp_resp, c_mst_snp_resp;
  logic             a_idle, b_idle, c_idle;

  ace_multicut #(.NumCuts(2), .ChanMask(8'hFF), .AckCuts(2)) u_a (
    .clk_i(clk), .rst_i(rst), .slv_req_i(a_slv_req), .slv_resp_o(a_slv_resp),
    .mst_req_o(a_mst_req), .mst_resp_i(a_mst_resp), .slv_snp_req_o(a_slv_snp_req),
    .slv_snp_resp_i(a_slv_snp_resp), .mst_snp_req_i(a_mst_snp_req),
    .mst_snp_resp_o(a_mst_snp_resp), .idle_o(a_idle));

  ace_multicut #(.NumCuts(3), .ChanMask(8'hDF), .AckCuts(1)) u_b (
    .clk_i(clk), .rst_i(rst), .slv_req_i(b_slv_req), .slv_resp_o(b_slv_resp),
    .mst_req_o(b_mst_req), .mst_resp_i(b_mst_resp), .slv_snp_req_o(b_slv_snp_req),
    .slv_snp_resp_i(b_slv_snp_resp), .mst_snp_req_i(b_mst_snp_req),
    .mst_snp_resp_o(b_mst_snp_resp), .idle_o(b_idle));

  ace_multicut #(.NumCuts(0), .ChanMask(8'hFF), .AckCuts(0)) u_c (
    .clk_i(clk), .rst_i(rst), .slv_req_i(c_slv_req), .slv_resp_o(c_slv_resp),
    .mst_req_o(c_mst_req), .mst_resp_i(c_mst_resp), .slv_snp_req_o(c_slv_snp_req),
    .slv_snp_resp_i(c_slv_snp_resp), .mst_snp_req_i(c_mst_snp_req),
    .mst_snp_resp_o(c_mst_snp_resp), .idle_o(c_idle));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: each cut channel is an in-order FIFO with fixed latency when unstalled.
  ace_mc_aw_t  aw_q[$];
  int unsigned aw_cq[$];
  ace_mc_w_t   w_q[$];
  ace_mc_r_t   r_q[$];
  int unsigned r_cq[$];
  ace_mc_cr_t  cr_q[$];
  int unsigned cr_cq[$];
  bit          r_lat_chk = 1'b0;
  bit          w_held = 1'b0, r_held = 1'b0;
  ace_mc_w_t   w_hold;
  ace_mc_r_t   r_hold;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_slv_req.aw_valid && a_slv_resp.aw_ready) begin
        aw_q.push_back(a_slv_req.aw);
        aw_cq.push_back(cyc);
      end
      if (a_mst_req.aw_valid && a_mst_resp.aw_ready) begin
        if (aw_q.size() == 0) chk("aw_spurious", 64'(a_mst_req.aw_valid), 64'(0));
        else begin
          chk("aw_data", 64'(a_mst_req.aw), 64'(aw_q.pop_front()));
          chk("aw_latency", 64'(cyc - aw_cq.pop_front()), 64'(2));
        end
      end

      if (a_slv_req.w_valid && a_slv_resp.w_ready) w_q.push_back(a_slv_req.w);
      if (a_mst_req.w_valid && w_held) chk("w_stable", 64'(a_mst_req.w), 64'(w_hold));
      w_held <= a_mst_req.w_valid && !a_mst_resp.w_ready;
      w_hold <= a_mst_req.w;
      if (a_mst_req.w_valid && a_mst_resp.w_ready) begin
        if (w_q.size() == 0) chk("w_spurious", 64'(a_mst_req.w_valid), 64'(0));
        else chk("w_data", 64'(a_mst_req.w), 64'(w_q.pop_front()));
      end

      if (a_mst_resp.r_valid && a_mst_req.r_ready) begin
        r_q.push_back(a_mst_resp.r);
        r_cq.push_back(cyc);
      end
      if (a_slv_resp.r_valid && r_held) chk("r_stable", 64'(a_slv_resp.r), 64'(r_hold));
      r_held <= a_slv_resp.r_valid && !a_slv_req.r_ready;
      r_hold <= a_slv_resp.r;
      if (a_slv_resp.r_valid && a_slv_req.r_ready) begin
        if (r_q.size() == 0) chk("r_spurious", 64'(a_slv_resp.r_valid), 64'(0));
        else begin
          chk("r_data", 64'(a_slv_resp.r), 64'(r_q.pop_front()));
          if (r_lat_chk) chk("r_latency", 64'(cyc - r_cq.pop_front()), 64'(2));
          else void'(r_cq.pop_front());
        end
      end

      if (b_slv_snp_resp.cr_valid && b_slv_snp_req.cr_ready) begin
        cr_q.push_back(b_slv_snp_resp.cr);
        cr_cq.push_back(cyc);
      end
      if (b_mst_snp_resp.cr_valid && b_mst_snp_req.cr_ready) begin
        if (cr_q.size() == 0) chk("cr_spurious", 64'(b_mst_snp_resp.cr_valid), 64'(0));
        else begin
          chk("cr_data", 64'(b_mst_snp_resp.cr), 64'(cr_q.pop_front()));
          chk("cr_latency", 64'(cyc - cr_cq.pop_front()), 64'(3));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  n_acc;
    bit  win [0:15];
    bit  rin [0:15];
    logic [63:0] exp_w, exp_r;

    a_slv_req = '0; a_mst_resp = '0; a_slv_snp_resp = '0; a_mst_snp_req = '0;
    b_slv_req = '0; b_mst_resp = '0; b_slv_snp_resp = '0; b_mst_snp_req = '0;
    c_slv_req = '0; c_mst_resp = '0; c_slv_snp_resp = '0; c_mst_snp_req = '0;
    a_mst_resp.aw_ready = 1'b1; a_mst_resp.w_ready = 1'b1; a_mst_resp.ar_ready = 1'b1;
    a_slv_req.b_ready = 1'b1; a_slv_req.r_ready = 1'b1;
    a_mst_snp_req.cr_ready = 1'b1; a_mst_snp_req.cd_ready = 1'b1; a_slv_snp_resp.ac_ready = 1'b1;
    b_mst_snp_req.cr_ready = 1'b1; b_mst_snp_req.cd_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_valid", 64'(a_mst_req.aw_valid), 64'(0));
    chk("rst_r_valid", 64'(a_slv_resp.r_valid), 64'(0));
    chk("rst_wack", 64'(a_mst_req.wack), 64'(0));
    chk("rst_idle", 64'(a_idle), 64'(1));
    chk("rst_aw_ready", 64'(a_slv_resp.aw_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_aw_ready", 64'(a_slv_resp.aw_ready), 64'(1));
    chk("post_rst_cr_ready", 64'(b_slv_snp_req.cr_ready), 64'(1));

    // Back-to-back AW burst, sink always ready
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a_slv_req.aw_valid   = 1'b1;
      a_slv_req.aw.id      = 4'($urandom);
      a_slv_req.aw.addr    = 32'h100 + 32'(i);
      a_slv_req.aw.len     = 8'($urandom);
      if (i == 1) chk("idle_after_accept", 64'(a_idle), 64'(0));
      if (i == 0) begin
        @(negedge clk);
        chk("idle_before_accept", 64'(a_idle), 64'(1));
      end
    end
    @(posedge clk); #1;
    a_slv_req.aw_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("aw_drained", 64'(aw_q.size()), 64'(0));
    chk("idle_after_aw", 64'(a_idle), 64'(1));

    // W sink stalled: fill to capacity, hold, then release
    a_mst_resp.w_ready = 1'b0;
    a_slv_req.w_valid  = 1'b1;
    a_slv_req.w.data   = $urandom;
    a_slv_req.w.strb   = 4'($urandom);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!a_slv_resp.w_ready) break;
      n_acc++;
      @(posedge clk); #1;
      a_slv_req.w.data = $urandom;
      a_slv_req.w.strb = 4'($urandom);
    end
    @(posedge clk); #1;
    a_slv_req.w_valid = 1'b0;
    chk("w_capacity", 64'(n_acc), 64'(4));
    repeat (5) @(posedge clk);
    #1;
    a_mst_resp.w_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("w_drained", 64'(w_q.size()), 64'(0));

    // Random R traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      a_mst_resp.r_valid  = ($urandom % 3) != 0;
      a_mst_resp.r.id     = 4'($urandom);
      a_mst_resp.r.data   = $urandom;
      a_mst_resp.r.resp   = 4'($urandom);
      a_mst_resp.r.last   = 1'($urandom);
      a_slv_req.r_ready   = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    a_mst_resp.r_valid = 1'b0;
    a_slv_req.r_ready  = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("r_drained", 64'(r_q.size()), 64'(0));

    // Ack delay lines
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      #1;
      win[k] = (k == 5) || (k == 6) || (k == 9);
      rin[k] = (k == 6);
      a_slv_req.wack = win[k];
      a_slv_req.rack = rin[k];
      exp_w = (k >= 2) ? 64'(win[k-2]) : 64'(0);
      exp_r = (k >= 2) ? 64'(rin[k-2]) : 64'(0);
      @(negedge clk);
      chk("wack_delay", 64'(a_mst_req.wack), exp_w);
      chk("rack_delay", 64'(a_mst_req.rack), exp_r);
      @(posedge clk);
    end
    #1;
    a_slv_req.wack = 1'b0;
    a_slv_req.rack = 1'b0;

    // Reset with R beats buffered
    a_slv_req.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_mst_resp.r_valid = 1'b1;
      a_mst_resp.r.data  = $urandom;
      @(posedge clk); #1;
    end
    a_mst_resp.r_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("r_buffered_valid", 64'(a_slv_resp.r_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("midrst_r_valid", 64'(a_slv_resp.r_valid), 64'(0));
    chk("midrst_idle", 64'(a_idle), 64'(1));
    chk("midrst_r_ready", 64'(a_mst_req.r_ready), 64'(0));
    r_q.delete(); r_cq.delete(); aw_q.delete(); aw_cq.delete(); w_q.delete();
    cr_q.delete(); cr_cq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_slv_req.r_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    r_lat_chk = 1'b1;
    a_mst_resp.r_valid = 1'b1;
    a_mst_resp.r.data  = $urandom;
    @(posedge clk); #1;
    a_mst_resp.r_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("r_post_rst_drained", 64'(r_q.size()), 64'(0));
    r_lat_chk = 1'b0;

    // Bypassed AC on the 3-cut instance
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      b_mst_snp_req.ac_valid    = 1'($urandom);
      b_mst_snp_req.ac.addr     = $urandom;
      b_mst_snp_req.ac.snoop    = 4'($urandom);
      b_slv_snp_resp.ac_ready   = 1'($urandom);
      #1;
      chk("ac_bypass_valid", 64'(b_slv_snp_req.ac_valid), 64'(b_mst_snp_req.ac_valid));
      chk("ac_bypass_data", 64'(b_slv_snp_req.ac), 64'(b_mst_snp_req.ac));
      chk("ac_bypass_ready", 64'(b_mst_snp_resp.ac_ready), 64'(b_slv_snp_resp.ac_ready));
    end
    chk("b_idle_bypass", 64'(b_idle), 64'(1));

    // CR on the 3-cut instance
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      b_slv_snp_resp.cr_valid = 1'($urandom);
      b_slv_snp_resp.cr.resp  = 5'($urandom);
    end
    @(posedge clk); #1;
    b_slv_snp_resp.cr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("cr_drained", 64'(cr_q.size()), 64'(0));

    // Zero-cut instance is fully transparent
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      c_slv_req.aw_valid      = 1'($urandom);
      c_slv_req.aw.addr       = $urandom;
      c_mst_resp.aw_ready     = 1'($urandom);
      c_mst_resp.r_valid      = 1'($urandom);
      c_mst_resp.r.data       = $urandom;
      c_slv_req.wack          = 1'($urandom);
      c_slv_snp_resp.cd_valid = 1'($urandom);
      c_slv_snp_resp.cd.data  = $urandom;
      #1;
      chk("c_aw_valid", 64'(c_mst_req.aw_valid), 64'(c_slv_req.aw_valid));
      chk("c_aw_data", 64'(c_mst_req.aw), 64'(c_slv_req.aw));
      chk("c_aw_ready", 64'(c_slv_resp.aw_ready), 64'(c_mst_resp.aw_ready));
      chk("c_r_data", 64'(c_slv_resp.r), 64'(c_mst_resp.r));
      chk("c_wack", 64'(c_mst_req.wack), 64'(c_slv_req.wack));
      chk("c_cd_data", 64'(c_mst_snp_resp.cd), 64'(c_slv_snp_resp.cd));
      chk("c_idle", 64'(c_idle), 64'(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
